// File: rtl/fmul_result_queue.sv
// fmul_result_queue: tags fmul results through a latency-matched delay line and buffers them for credit-gated writeback
module fmul_result_queue #(
  parameter int LATENCY = 1,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic issue_ready,
  input  logic [31:0] fmul_y,
  input  logic fmul_ovf,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_y,
  output logic out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic sticky_ovf,
  input  logic clr_sticky
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = TAG_W + 33;
  logic [LATENCY-1:0] v;
  logic [TAG_W-1:0] t [LATENCY];
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [31:0] used;
  logic fire, push, pop;
  // credits count in-flight tags plus stored entries, so a push always finds room
  always_comb begin
    used = 32'(occupancy);
    for (int i = 0; i < LATENCY; i++) used = used + 32'(v[i]);
  end
  assign issue_ready = used < 32'(DEPTH);
  assign fire = issue_valid & issue_ready;
  assign push = v[LATENCY-1];
  assign out_valid = occupancy != '0;
  assign pop = out_valid & out_ready;
  assign {out_y, out_ovf, out_tag} = out_valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    t[0] <= issue_tag;
    for (int i = 1; i < LATENCY; i++) t[i] <= t[i-1];
    if (push) mem[wp] <= {fmul_y, fmul_ovf, t[LATENCY-1]};
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      v <= '0;
      wp <= '0;
      rp <= '0;
      occupancy <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      assert (!(push && occupancy == CW'(DEPTH)));
      v[0] <= fire;
      for (int i = 1; i < LATENCY; i++) v[i] <= v[i-1];
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      occupancy <= occupancy + CW'(push) - CW'(pop);
      sticky_ovf <= (pop & out_ovf) ? 1'b1 : clr_sticky ? 1'b0 : sticky_ovf;
    end
  end
endmodule

// File: tb/tb_fmul_result_queue.sv
// tb_fmul_result_queue: drives a LATENCY=1/DEPTH=4 and a LATENCY=3/DEPTH=8 queue against a sequence-numbered scoreboard
module tb_fmul_result_queue;
  typedef struct packed {
    logic [4:0] tag;
    logic [31:0] y;
    logic ovf;
    int due;
  } op_t;
  localparam int N = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] iv, rdy, ov, oo, ordy, clr, rst, fo, sk, opo;
  logic [1:0][4:0] tg, ot;
  logic [1:0][31:0] fy, oy, opy;
  logic [2:0] occ0;
  logic [3:0] occ1;
  op_t ops [2][N];
  int nfire[2], npush[2], npop[2], tgt[2], b0[2];
  int cyc, ncmp, nbad, base;
  logic esk[2];
  fmul_result_queue #(.LATENCY(1), .DEPTH(4), .TAG_W(5)) u0 (
    .clk(clk), .rstn(rst[0]), .issue_valid(iv[0]), .issue_tag(tg[0]), .issue_ready(rdy[0]),
    .fmul_y(fy[0]), .fmul_ovf(fo[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_y(oy[0]),
    .out_ovf(oo[0]), .out_tag(ot[0]), .occupancy(occ0), .sticky_ovf(sk[0]), .clr_sticky(clr[0]));
  fmul_result_queue #(.LATENCY(3), .DEPTH(8), .TAG_W(5)) u1 (
    .clk(clk), .rstn(rst[1]), .issue_valid(iv[1]), .issue_tag(tg[1]), .issue_ready(rdy[1]),
    .fmul_y(fy[1]), .fmul_ovf(fo[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_y(oy[1]),
    .out_ovf(oo[1]), .out_tag(ot[1]), .occupancy(occ1), .sticky_ovf(sk[1]), .clr_sticky(clr[1]));
  function automatic int dep(input int i);
    return i != 0 ? 8 : 4;
  endfunction
  function automatic int lat(input int i);
    return i != 0 ? 3 : 1;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // one clock: present fmul result when due, compare, advance the model, cross the edge
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      op_t h = ops[i][npush[i] % N];
      fy[i] = $urandom;
      fo[i] = 1'($urandom);
      if (nfire[i] > npush[i] && h.due == cyc) begin
        fy[i] = h.y;
        fo[i] = h.ovf;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      op_t hd = ops[i][npop[i] % N];
      logic vld = npush[i] > npop[i];
      logic r = (nfire[i] - npop[i]) < dep(i);
      logic [3:0] occ = i != 0 ? occ1 : {1'b0, occ0};
      chk($sformatf("u%0d_issue_ready", i), 64'(rdy[i]), 64'(r));
      chk($sformatf("u%0d_out_valid", i), 64'(ov[i]), 64'(vld));
      chk($sformatf("u%0d_out_y", i), 64'(oy[i]), vld ? 64'(hd.y) : 64'(0));
      chk($sformatf("u%0d_out_ovf", i), 64'(oo[i]), 64'(vld & hd.ovf));
      chk($sformatf("u%0d_out_tag", i), 64'(ot[i]), vld ? 64'(hd.tag) : 64'(0));
      chk($sformatf("u%0d_occupancy", i), 64'(occ), 64'(npush[i] - npop[i]));
      chk($sformatf("u%0d_sticky_ovf", i), 64'(sk[i]), 64'(esk[i]));
      if (rst[i]) begin
        npush[i] = nfire[i];
        npop[i] = nfire[i];
        esk[i] = 1'b0;
      end else begin
        if (vld && ordy[i] && hd.ovf) esk[i] = 1'b1;
        else if (clr[i]) esk[i] = 1'b0;
        if (vld && ordy[i]) npop[i]++;
        if (nfire[i] > npush[i] && ops[i][npush[i] % N].due == cyc) begin
          chk($sformatf("u%0d_push_room", i), 64'(occ < 4'(dep(i))), 64'(1));
          npush[i]++;
        end
        if (iv[i] && r) begin
          ops[i][nfire[i] % N] = '{tg[i], opy[i], opo[i], cyc + lat(i)};
          nfire[i]++;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    ncmp = 0;
    nbad = 0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      nfire[i] = 0;
      npush[i] = 0;
      npop[i] = 0;
      esk[i] = 1'b0;
    end
    iv = '0; tg = '0; ordy = '0; clr = '0; opy = '0; opo = '0; fy = '0; fo = '0;
    rst = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst = '0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_reset_ready", i), 64'(rdy[i]), 64'(1));
      chk($sformatf("u%0d_reset_valid", i), 64'(ov[i]), 64'(0));
      chk($sformatf("u%0d_reset_y", i), 64'(oy[i]), 64'(0));
      chk($sformatf("u%0d_reset_tag", i), 64'(ot[i]), 64'(0));
      chk($sformatf("u%0d_reset_sticky", i), 64'(sk[i]), 64'(0));
    end
    chk("u0_reset_occ", 64'(occ0), 64'(0));
    chk("u1_reset_occ", 64'(occ1), 64'(0));
    // 1.5 * 2.0 = 3.0, tag 3
    iv[0] = 1'b1; tg[0] = 5'd3; opy[0] = 32'h40400000; opo[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    step();
    chk("single_valid", 64'(ov[0]), 64'(1));
    chk("single_y", 64'(oy[0]), 64'h40400000);
    chk("single_ovf", 64'(oo[0]), 64'(0));
    chk("single_tag", 64'(ot[0]), 64'(3));
    chk("single_occ1", 64'(occ0), 64'(1));
    ordy[0] = 1'b1;
    step();
    chk("single_occ0", 64'(occ0), 64'(0));
    // 2^127 * 2^127 overflows to +inf
    iv[0] = 1'b1; tg[0] = 5'd7; opy[0] = 32'h7f800000; opo[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    chk("ovf_y", 64'(oy[0]), 64'h7f800000);
    chk("ovf_flag", 64'(oo[0]), 64'(1));
    chk("ovf_tag", 64'(ot[0]), 64'(7));
    chk("ovf_sticky_before", 64'(sk[0]), 64'(0));
    step();
    chk("ovf_sticky_set", 64'(sk[0]), 64'(1));
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("ovf_sticky_clr", 64'(sk[0]), 64'(0));
    // backpressure: only DEPTH fires while writeback is stalled
    ordy[0] = 1'b0; iv[0] = 1'b1; opo[0] = 1'b0;
    base = nfire[0];
    repeat (8) begin
      tg[0] = 5'(nfire[0] - base);
      opy[0] = $urandom;
      step();
    end
    iv[0] = 1'b0;
    chk("bp_ready_low", 64'(rdy[0]), 64'(0));
    chk("bp_occ_full", 64'(occ0), 64'(4));
    ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_order_%0d", k), 64'(ot[0]), 64'(k));
      step();
      if (k == 0) chk("bp_ready_back", 64'(rdy[0]), 64'(1));
    end
    // streaming on the LATENCY=3 instance
    ordy[1] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      iv[1] = k < 20;
      tg[1] = 5'(k);
      opy[1] = $urandom;
      opo[1] = 1'($urandom);
      if (k < 20) chk("stream_ready", 64'(rdy[1]), 64'(1));
      if (k >= 4 && k < 24) chk("stream_nobubble", 64'(ov[1]), 64'(1));
      chk("stream_occ_le1", 64'(occ1 <= 4'd1), 64'(1));
      step();
    end
    iv[1] = 1'b0;
    // reset with two results stored and two in flight
    ordy[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv[1] = 1'b1;
      tg[1] = 5'(20 + k);
      opy[1] = $urandom;
      step();
    end
    iv[1] = 1'b0;
    step();
    chk("rst_pre_occ", 64'(occ1), 64'(2));
    rst[1] = 1'b1; iv[1] = 1'b1; tg[1] = 5'd31;
    step();
    rst[1] = 1'b0; iv[1] = 1'b0;
    chk("rst_valid", 64'(ov[1]), 64'(0));
    chk("rst_occ", 64'(occ1), 64'(0));
    chk("rst_ready", 64'(rdy[1]), 64'(1));
    chk("rst_sticky", 64'(sk[1]), 64'(0));
    ordy[1] = 1'b1;
    repeat (6) step();
    // random wrap-around on both instances
    for (int i = 0; i < 2; i++) begin
      tgt[i] = 3 * dep(i) + 1;
      b0[i] = nfire[i];
    end
    for (int c = 0; c < 3000 && (npop[0] - b0[0] < tgt[0] || npop[1] - b0[1] < tgt[1]); c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i] = (nfire[i] - b0[i] < tgt[i]) && $urandom_range(0, 3) != 0;
        tg[i] = 5'($urandom);
        opy[i] = $urandom;
        opo[i] = 1'($urandom);
        ordy[i] = 1'($urandom);
        clr[i] = $urandom_range(0, 7) == 0;
      end
      step();
    end
    iv = '0; clr = '0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_wrap_delivered", i), 64'(npop[i] - b0[i]), 64'(tgt[i]));
      chk($sformatf("u%0d_wrap_empty", i), 64'(ov[i]), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/fmul_result_queue.md
Name: fmul_result_queue

Overview:
- Sits directly downstream of the pipelined fmul unit, between fmul and the FPU writeback path.
- Tracks each issued multiply's destination tag through a delay line that matches fmul's latency.
- Pairs each tag with fmul's y/ovf when the result emerges, and buffers tagged results in a FIFO drained by a valid/ready writeback handshake.
- Gates issue by credits, so a stalled writeback never drops a result.

Parameters:
- LATENCY, 1: fmul pipeline depth in cycles, from operands presented to y/ovf valid; must be >= 1.
- DEPTH, 4: FIFO entries; also the total credit limit (in-flight plus stored); power of two, >= 2.
- TAG_W, 5: width of destination register tag.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge.
- issue_valid  in  1  operands for this cycle are being presented to fmul.
- issue_tag  in  TAG_W  destination tag of that multiply.
- issue_ready  out  1  queue can accept an issue this cycle.
- fmul_y  in  32  fmul result (IEEE single).
- fmul_ovf  in  1  fmul overflow flag.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  writeback accepts head.
- out_y  out  32  head result.
- out_ovf  out  1  head overflow flag.
- out_tag  out  TAG_W  head tag.
- occupancy  out  $clog2(DEPTH+1)  stored entries.
- sticky_ovf  out  1  set when any entry with ovf=1 is popped.
- clr_sticky  in  1  clears sticky_ovf.

Behaviour:
- Issue fires on issue_valid & issue_ready; nothing is recorded otherwise.
- Delay line: LATENCY stages of {v, tag}. Stage 0 loads {fire, issue_tag}; each stage shifts every cycle, with no stalls.
- Capture: when the last stage has v=1, the cycle after the shift makes it visible, push {fmul_y, fmul_ovf, tag} into the FIFO at that edge.
  - fmul_y/fmul_ovf are sampled in the cycle the tag reaches the last stage, i.e. exactly LATENCY cycles after the fire cycle.
- Credits:
  - inflight = count of v bits in the delay line.
  - issue_ready = (inflight + occupancy) < DEPTH, computed from registered values only. A pop in the same cycle does not free a credit until the next cycle.
  - A push therefore never finds the FIFO full; an overflow is an assertion error.
- FIFO:
  - First-word fall-through: out_* show the head combinationally from storage.
  - out_valid = (occupancy != 0).
  - Pop on out_valid & out_ready.
  - Pointers wrap modulo DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged; both pointers advance.
  - Push into an empty FIFO: out_valid rises the next cycle, with no bypass.
- out_* when out_valid=0: out_y, out_ovf and out_tag are driven 0.
- sticky_ovf:
  - Set on a pop with out_ovf=1.
  - clr_sticky clears it.
  - Set and clear in the same cycle: set wins.
- Reset, including mid-operation: all v bits, pointers, occupancy and sticky_ovf go to 0; in-flight results are discarded.
  - Outputs after reset: issue_ready=1, out_valid=0, out_y=0, out_ovf=0, out_tag=0, occupancy=0, sticky_ovf=0.
  - During the reset cycle, issue_valid is ignored.
- Ordering: results leave strictly in issue order.

Test Plan:
- Single op, LATENCY=1: issue tag 3 with fmul modelled as 0x3fc00000*0x40000000 -> out_valid two cycles after fire; out_y=0x40400000, out_ovf=0, out_tag=3; occupancy 1 then 0 after pop.
- Overflow: 0x7f000000*0x7f000000 with tag 7 -> out_y=0x7f800000, out_ovf=1; sticky_ovf=1 the cycle after the pop; clr_sticky returns it to 0.
- Backpressure, DEPTH=4, out_ready=0, issue_valid held high -> exactly 4 fires (tags 0..3), after which issue_ready=0. Then release out_ready -> pops in order 0,1,2,3; issue_ready reasserts one cycle after the first pop.
- Streaming: out_ready=1, issue every cycle for 20 ops, LATENCY=3 -> no bubbles after fill, occupancy stays <= 1, and tags emerge in order with matching products.
- Reset mid-operation: assert rstn for one cycle with 2 in flight and 2 stored -> next cycle out_valid=0, occupancy=0, issue_ready=1, and the discarded tags never appear.
- Wrap-around: 3*DEPTH+1 ops with random out_ready -> every result is delivered exactly once, in order, and no push ever occurs while occupancy==DEPTH.
